// File: rtl/mig1_pkg.sv
// Shared constants and LOAD/SERVE state encoding for the mig1 instruction memory.
package mig1_pkg;
  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] NOP_WORD   = 32'h0000_0000;
  localparam logic [WORD_WIDTH-1:0] FAULT_WORD = 32'hDEAD_BEEF;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;
endpackage

// File: rtl/mig1_imem_ram.sv
// Instruction word storage: one write port, one synchronous read port, no reset on contents.
module mig1_imem_ram
  import mig1_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data
);
  logic [WORD_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [WORD_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/mig1_imem.sv
// Boot-loaded instruction memory: LOAD fills words sequentially, SERVE answers fetches with 1-cycle latency.
// Optional fetch range check against the loaded image size: MIG1_IMEM_RANGE_CHECK_EN.
module mig1_imem
  import mig1_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_WIDTH-1:0] imem_data,
  output logic                  imem_ready,
  input  logic                  load_valid,
  input  logic [WORD_WIDTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  load_done,
  output logic [DEPTH_LOG2:0]   load_count,
  output logic                  fault
);
  state_e                state_q, state_d;
  logic [DEPTH_LOG2:0]   load_count_q, load_count_d;
  logic                  rd_vld_q;
  logic                  oor_q, oor_d;
  logic                  wr_en;
  logic                  last_wr;
  logic [WORD_WIDTH-1:0] ram_rd_data;

  assign wr_en   = (state_q == ST_LOAD) && load_valid && !reset;
  assign last_wr = wr_en && (&load_count_q[DEPTH_LOG2-1:0]);

  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    if (state_q == ST_LOAD) begin
      if (wr_en) begin
        load_count_d = load_count_q + 1'b1;
      end
      // A word offered alongside load_done is still written before the switch.
      if (load_done || last_wr) begin
        state_d = ST_SERVE;
      end
    end
  end

`ifdef MIG1_IMEM_RANGE_CHECK_EN
  logic fault_q;

  assign oor_d = (state_q == ST_SERVE) && (imem_addr >= ADDR_WIDTH'(load_count_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (oor_d) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  logic unused_addr_hi;

  assign oor_d          = 1'b0;
  assign unused_addr_hi = ^imem_addr[ADDR_WIDTH-1:DEPTH_LOG2];
  assign fault          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      load_count_q <= '0;
      rd_vld_q     <= 1'b0;
      oor_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      rd_vld_q     <= (state_q == ST_SERVE);
      oor_q        <= oor_d;
    end
  end

  mig1_imem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(load_count_q[DEPTH_LOG2-1:0]),
    .wr_data(load_data),
    .rd_addr(imem_addr[DEPTH_LOG2-1:0]),
    .rd_data(ram_rd_data)
  );

  // Output is NOP until a fetch issued in SERVE has had its read cycle.
  assign imem_data  = rd_vld_q ? (oor_q ? FAULT_WORD : ram_rd_data) : NOP_WORD;
  assign imem_ready = (state_q == ST_SERVE);
  assign load_ready = (state_q == ST_LOAD);
  assign load_count = load_count_q;
endmodule

// File: tb/tb_mig1_imem.sv
// Self-checking bench for mig1_imem: directed sequences, a read vector table and a randomized model check.
module tb_mig1_imem;
  import mig1_pkg::*;

  localparam int AW    = 32;
  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] imem_addr = '0;
  logic [31:0]   imem_data;
  logic          imem_ready;
  logic          load_valid = 1'b0;
  logic [31:0]   load_data = '0;
  logic          load_ready;
  logic          load_done = 1'b0;
  logic [DL:0]   load_count;
  logic          fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mig1_imem #(.ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .imem_ready(imem_ready),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .load_done (load_done),
    .load_count(load_count),
    .fault     (fault)
  );

  // Reference model: a word array with knowledge flags, a load counter and a serving flag.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_serve = 1'b0;
  int          m_count = 0;
  logic [31:0] m_exp = '0;
  bit          m_exp_known = 1'b0;
  bit          m_fault = 1'b0;

  always @(posedge clk) begin
    int idx;
    if (reset) begin
      m_serve = 1'b0; m_count = 0; m_exp = NOP_WORD; m_exp_known = 1'b1; m_fault = 1'b0;
    end else if (!m_serve) begin
      m_exp = NOP_WORD; m_exp_known = 1'b1;
      if (load_valid) begin
        m_mem[m_count] = load_data; m_known[m_count] = 1'b1; m_count = m_count + 1;
      end
      if (load_done || m_count == DEPTH) m_serve = 1'b1;
    end else begin
      idx = int'(imem_addr % DEPTH);
      m_exp = m_mem[idx]; m_exp_known = m_known[idx];
`ifdef MIG1_IMEM_RANGE_CHECK_EN
      if (imem_addr >= AW'(m_count)) begin
        m_exp = FAULT_WORD; m_exp_known = 1'b1; m_fault = 1'b1;
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d);
    load_valid = 1'b1; load_data = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string name);
    imem_addr = a;
    tick();
    chk(name, imem_data, exp);
  endtask

  task automatic do_reset;
    reset = 1'b1; load_valid = 1'b0; load_done = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_model;
    chk("rnd_imem_ready", 32'(imem_ready), 32'(m_serve));
    chk("rnd_load_ready", 32'(load_ready), 32'(!m_serve));
    chk("rnd_load_count", 32'(load_count), 32'(m_count));
    chk("rnd_fault", 32'(fault), 32'(m_fault));
    if (m_exp_known) chk("rnd_imem_data", imem_data, m_exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        flt;
  } rd_vec_t;

  rd_vec_t vt [8];

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

`ifdef MIG1_IMEM_RANGE_CHECK_EN
    vt[0] = '{32'd0, 32'h11, 1'b0};       vt[1] = '{32'd1, 32'h22, 1'b0};
    vt[2] = '{32'd2, 32'h33, 1'b0};       vt[3] = '{32'd3, 32'h44, 1'b0};
    vt[4] = '{32'd7, FAULT_WORD, 1'b1};   vt[5] = '{32'd1, 32'h22, 1'b1};
    vt[6] = '{32'd1024, FAULT_WORD, 1'b1}; vt[7] = '{32'd0, 32'h11, 1'b1};
`else
    vt[0] = '{32'd0, 32'h11, 1'b0};       vt[1] = '{32'd1, 32'h22, 1'b0};
    vt[2] = '{32'd2, 32'h33, 1'b0};       vt[3] = '{32'd3, 32'h44, 1'b0};
    vt[4] = '{32'd1024, 32'h11, 1'b0};    vt[5] = '{32'd1027, 32'h44, 1'b0};
    vt[6] = '{32'd2050, 32'h33, 1'b0};    vt[7] = '{32'hFFFF_FC01, 32'h22, 1'b0};
`endif

    // Reset state
    tick(); tick();
    chk("rst_imem_data", imem_data, NOP_WORD);
    chk("rst_imem_ready", 32'(imem_ready), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;

    // Four-word boot image then load_done
    load_word(32'h11); load_word(32'h22); load_word(32'h33); load_word(32'h44);
    chk("load_imem_data_nop", imem_data, NOP_WORD);
    chk("load_ready_still", 32'(imem_ready), 32'd0);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("done_load_count", 32'(load_count), 32'd4);
    chk("done_imem_ready", 32'(imem_ready), 32'd1);
    chk("done_load_ready", 32'(load_ready), 32'd0);
    chk("done_first_data_nop", imem_data, NOP_WORD);

    // Back-to-back reads, with load_valid asserted to show it is ignored in SERVE
    load_valid = 1'b1; load_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      fetch(vt[i].addr, vt[i].data, $sformatf("table_data_%0d", i));
      chk($sformatf("table_fault_%0d", i), 32'(fault), 32'(vt[i].flt));
    end
    load_valid = 1'b0;
    chk("serve_count_frozen", 32'(load_count), 32'd4);

    // Reset in SERVE, reload one word, older words survive
    reset = 1'b1;
    tick();
    chk("rst2_imem_data", imem_data, NOP_WORD);
    chk("rst2_imem_ready", 32'(imem_ready), 32'd0);
    chk("rst2_load_count", 32'(load_count), 32'd0);
    chk("rst2_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    load_word(32'h99);
    load_done = 1'b1; tick(); load_done = 1'b0;
    fetch(32'd0, 32'h99, "reload_addr0");
`ifdef MIG1_IMEM_RANGE_CHECK_EN
    fetch(32'd1, FAULT_WORD, "reload_addr1_oor");
`else
    fetch(32'd1, 32'h22, "reload_addr1_stale");
`endif

    // load_valid and load_done together at count 2
    do_reset();
    load_word(32'hA1); load_word(32'hA2);
    load_valid = 1'b1; load_data = 32'h55; load_done = 1'b1;
    tick();
    load_valid = 1'b0; load_done = 1'b0;
    chk("vd_load_count", 32'(load_count), 32'd3);
    chk("vd_imem_ready", 32'(imem_ready), 32'd1);
    fetch(32'd2, 32'h55, "vd_addr2");

    // Empty image
    do_reset();
    load_done = 1'b1; tick(); load_done = 1'b0;
    chk("empty_imem_ready", 32'(imem_ready), 32'd1);
    chk("empty_load_count", 32'(load_count), 32'd0);

    // Full memory without load_done, with random idle gaps
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      chk("full_still_loading", 32'(load_ready), 32'd1);
      load_word(32'hC000_0000 + 32'(i) * 32'h0001_0003);
    end
    chk("full_imem_ready", 32'(imem_ready), 32'd1);
    chk("full_load_ready", 32'(load_ready), 32'd0);
    chk("full_load_count", 32'(load_count), 32'(DEPTH));
    fetch(32'(DEPTH), 32'hC000_0000, "full_wrap_word0");
    fetch(32'(DEPTH - 1), 32'hC000_0000 + 32'(DEPTH - 1) * 32'h0001_0003, "full_last_word");

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset      = ($urandom_range(0, 99) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_data  = $urandom;
      load_done  = ($urandom_range(0, 29) == 0);
      imem_addr  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
      tick();
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mig1_imem.md
MIG1_IMEM -- requirements
Module: mig1_imem

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, width of imem_addr (word address issued by the core).
REQ-002 Parameter: DEPTH_LOG2, 10, log2 of memory depth in 32-bit words.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: imem_addr  input  ADDR_WIDTH  instruction word address from the core.
REQ-006 Port: imem_data  output  32  instruction word returned to the core.
REQ-007 Port: imem_ready  output  1  high while in SERVE state.
REQ-008 Port: load_valid  input  1  boot-load word present on load_data.
REQ-009 Port: load_data  input  32  boot-load instruction word.
REQ-010 Port: load_ready  output  1  high while in LOAD state.
REQ-011 Port: load_done  input  1  end of boot image; sampled only in LOAD.
REQ-012 Port: load_count  output  DEPTH_LOG2+1  number of words written since reset.
REQ-013 Port: fault  output  1  sticky out-of-range fetch flag (see Configuration).

Function
REQ-014 States: LOAD and SERVE only; reset enters LOAD.
REQ-015 LOAD: word written at index load_count on cycle where load_valid && load_ready; load_count increments by 1 same edge.
REQ-016 LOAD -> SERVE on edge where load_done is high, or where the write targets index 2**DEPTH_LOG2-1 (memory full).
REQ-017 load_done with load_valid in same cycle: word written first, then transition; load_count includes it.
REQ-018 load_done with load_count==0 and no load_valid: transition to SERVE with empty image (all reads return stale/uninitialised contents).
REQ-019 SERVE: load_valid ignored, load_ready low, no writes, load_count frozen.
REQ-020 SERVE read latency exactly 1 cycle: imem_data at edge N+1 = mem[imem_addr[DEPTH_LOG2-1:0]] sampled at edge N; imem_data registered.
REQ-021 imem_data updates every cycle in SERVE (no stall); consecutive different addresses yield back-to-back words.
REQ-022 In LOAD, imem_data held at NOP_WORD (0x00000000) every cycle.
REQ-023 First valid imem_data appears the cycle after imem_ready first rises.
REQ-024 Address bits above DEPTH_LOG2-1 ignored (modulo wrap) unless range check compiled in.

Reset
REQ-025 On reset: state=LOAD, load_count=0, imem_data=NOP_WORD, imem_ready=0, load_ready=1 after the reset cycle, fault=0.
REQ-026 Memory contents not cleared by reset; reset mid-SERVE or mid-LOAD aborts, restarts load at index 0, overwrites only words reloaded.
REQ-027 Reset has priority over all simultaneous load_valid/load_done events.

Configuration
REQ-028 Macro MIG1_IMEM_RANGE_CHECK_EN defined: in SERVE, a fetch with imem_addr >= load_count returns FAULT_WORD (0xDEADBEEF) one cycle later and sets fault sticky until reset.
REQ-029 Macro undefined: no range check, fault tied to 0, addresses wrap modulo 2**DEPTH_LOG2.

Structure
REQ-030 Shared package mig1_pkg holds WORD_WIDTH=32, NOP_WORD, FAULT_WORD and the LOAD/SERVE state encoding; the core also uses WORD_WIDTH from it.
REQ-031 One sub-module mig1_imem_ram: single write port, single synchronous read port, 32-bit words, depth 2**DEPTH_LOG2; FSM, counter and range check stay in mig1_imem.

Verification
REQ-032 Reset, load 4 words 0x11,0x22,0x33,0x44, then load_done -> load_count=4, imem_ready rises next cycle, load_ready low.
REQ-033 SERVE, imem_addr 0,1,2,3 on consecutive cycles -> imem_data 0x11,0x22,0x33,0x44 each one cycle later, no gaps.
REQ-034 Load 2**DEPTH_LOG2 words without load_done -> auto SERVE after last write; fetch at 2**DEPTH_LOG2 returns word 0 (macro off).
REQ-035 load_valid=1, load_data=0x55, load_done=1 same cycle at count 2 -> word written at index 2, load_count=3, SERVE.
REQ-036 Reset asserted in SERVE -> next cycle imem_data=0, imem_ready=0, load_count=0; reload 1 word 0x99 -> addr 0 returns 0x99, addr 1 returns prior 0x22.
REQ-037 Macro on, 4 words loaded, fetch addr 7 -> imem_data=0xDEADBEEF, fault=1, stays 1 after in-range fetches until reset.
